down_timer: RTL

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer.sv | 94 +++++++++
 1 files changed

// File: rtl/down_timer.sv
// Loadable down-counter with a one-cycle expiry pulse and a cancel input.
// Optional auto-reload of the last loaded value is enabled by defining DOWN_TIMER_RELOAD_EN.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             cancel,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
`ifdef DOWN_TIMER_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef DOWN_TIMER_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    count_d = load_value;
`ifdef DOWN_TIMER_RELOAD_EN
                    reload_d = load_value;
`endif
                    state_d = (load_value == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // cancel wins over enable and leaves the count where it stopped
                if (cancel) begin
                    state_d = IDLE;
                end else if (enable) begin
                    count_d = count_q - WIDTH'(1);
                    if (count_q == WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
`ifdef DOWN_TIMER_RELOAD_EN
                if (reload_q != '0) begin
                    state_d = RUN;
                    count_d = reload_q;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
`ifdef DOWN_TIMER_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
`ifdef DOWN_TIMER_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign expired    = (state_q == DONE);
    assign count_out  = count_q;

endmodule
